nt_frame_ctrl: RTL

Upstream control stage for the serial n-bit counter/shifter (nt_counter). It watches serin for a start bit and shifts in a HDR_W-bit length header, MSB first. It then pulses ldcnt3 with the header on len, and holds cnten3 high until the counter returns co3. It reports done, or err when the optional timeout fires, then re-arms for the next frame.

---
 rtl/nt_frame_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/nt_frame_ctrl.sv
// ---------------------------------------------------------------------------
// nt_frame_ctrl
//   Upstream control stage for the serial counter/shifter (nt_counter).
//   Waits for a start bit (serin low) while idle, shifts in an HDR_W-bit
//   length header MSB first, strobes ldcnt3 with the header on len, then
//   holds cnten3 until the counter reports co3. Signals done at frame end
//   and re-arms.
//
// Parameters:
//   HDR_W   - header / len width, equal to the downstream counter width
//   MAX_CYC - DATA-state cycle limit before timeout (TIMEOUT_EN only)
//
// Optional feature macro: TIMEOUT_EN
//   Defined     : watchdog aborts DATA after MAX_CYC cycles without co3,
//                 pulsing err through an ERR state.
//   Not defined : no watchdog, err tied low, DATA waits for co3 forever.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active high
//   serin  in   serial line (idle high, start bit = 0)
//   co3    in   carry-out from the downstream counter
//   ldcnt3 out  one-cycle counter load strobe
//   cnten3 out  counter count enable
//   len    out  header value for the counter, held until next load
//   busy   out  high whenever not idle
//   done   out  one-cycle frame-complete pulse
//   err    out  one-cycle timeout pulse
//
// All outputs decode from registers only; no input-to-output path.
// ---------------------------------------------------------------------------
module nt_frame_ctrl #(
  parameter int unsigned HDR_W   = 3,
  parameter int unsigned MAX_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serin,
  input  logic             co3,
  output logic             ldcnt3,
  output logic             cnten3,
  output logic [HDR_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if ((HDR_W < 1) || (MAX_CYC < 1)) begin : g_bad_param
    $error("nt_frame_ctrl: HDR_W and MAX_CYC must be at least 1");
  end

  localparam int unsigned CW = (HDR_W > 1) ? $clog2(HDR_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(HDR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
`ifdef TIMEOUT_EN
    ,
    S_ERR  = 3'd5
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [HDR_W-1:0] len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;

`ifdef TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(MAX_CYC) + 1;
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!serin) state_d = S_HDR;
      end
      S_HDR: begin
        // Truncating cast drops the oldest bit; also valid for HDR_W == 1.
        hdr_d = HDR_W'({hdr_q, serin});
        if (cnt_q == LAST_BIT) begin
          // len is captured on the way into LOAD so it is valid with ldcnt3.
          len_d   = hdr_d;
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD: begin
`ifdef TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = S_DATA;
      end
      S_DATA: begin
`ifdef TIMEOUT_EN
        wd_d = wd_q + WD_W'(1);
        // co3 takes priority over a coincident limit hit.
        if (co3)                         state_d = S_DONE;
        else if (wd_d == WD_W'(MAX_CYC)) state_d = S_ERR;
`else
        if (co3) state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
`ifdef TIMEOUT_EN
      S_ERR:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ldcnt3 = (state_q == S_LOAD);
    cnten3 = (state_q == S_DATA);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
`ifdef TIMEOUT_EN
    err    = (state_q == S_ERR);
`else
    err    = 1'b0;
`endif
    len    = len_q;
  end

endmodule
